load_store_unit: RTL



---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane.sv | 37 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// The optional MISALIGN_TRAP_EN build switch is consumed by load_store_unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; funct3[1:0] alone selects byte/half/word.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extract/extend and store merge for
// little-endian byte/half/word accesses within one 32-bit word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      F3_W:    ld_data = shifted;
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    st_word = word;
    case (funct3[1:0])
      2'b00:   st_word[{off, 3'b000} +: 8]         = st_data[7:0];
      2'b01:   st_word[{off[1], 4'b0000} +: 16]    = st_data[15:0];
      default: st_word                             = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-write data memory.
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0002_0000,
  parameter logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t      state, state_nx;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] wbuf;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  req_size;
  logic        f3_bad, range_bad, misalign, req_err, accept;
  logic [1:0]  eff_off;
  logic [31:0] word_addr;
  logic [31:0] ld_data, st_word;

  // Request decode, evaluated on the live request so errors resolve at accept.
  always_comb begin
    req_size  = f3_size(req_funct3);
    f3_bad    = req_we ? (req_funct3 > F3_W)
                       : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    range_bad = ({1'b0, req_addr} + {30'h0, req_size}) > {1'b0, ADDR_LIMIT};
`ifdef MISALIGN_TRAP_EN
    misalign  = (req_size == 3'd2 && req_addr[0]) ||
                (req_size == 3'd4 && req_addr[1:0] != 2'b00);
`else
    misalign  = 1'b0;
`endif
    req_err   = f3_bad | range_bad | misalign;
    accept    = req_valid && (state == S_IDLE);
  end

  // Without trapping, low address bits are forced to natural alignment here.
  always_comb begin
    case (f3_size(r_f3))
      3'd1:    eff_off = r_addr[1:0];
      3'd2:    eff_off = {r_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    word_addr = r_addr & ALIGN_MASK;
  end

  lsu_lane u_lane (
    .word    (mem_rd),
    .off     (eff_off),
    .funct3  (r_f3),
    .st_data (r_wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                  state_nx = S_RESP;
          else if (!req_we)             state_nx = S_LOAD;
          else if (req_funct3 == F3_W)  state_nx = S_WRITE;
          else                          state_nx = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_a    = word_addr;
        state_nx = S_RESP;
      end
      S_RMW_RD: begin
        mem_a    = word_addr;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_we   = r_we;
        mem_a    = word_addr;
        mem_wd   = wbuf;
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      wbuf    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        wbuf    <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state == S_LOAD)   rdata_q <= ld_data;
      if (state == S_RMW_RD) wbuf    <= st_word;
      if (state == S_RESP && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
